// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared controller state codes, display codes and answer FSM
//               state type for the calculator game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam logic [3:0] c_state_start    = 4'd1;
    localparam logic [3:0] c_state_blank    = 4'd2;
    localparam logic [3:0] c_state_question = 4'd3;
    localparam logic [3:0] c_state_answer   = 4'd4;
    localparam logic [3:0] c_state_score    = 4'd8;
    localparam logic [3:0] c_state_bye      = 4'd10;
    localparam logic [3:0] c_state_error    = 4'd11;

    // Response code the print stage renders as a minus sign.
    localparam logic [3:0] c_blank_code     = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } answer_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, level debouncer and single-tick pulse
//               on the debounced rising edge of a raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic tick,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_TICKS - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_count;
    logic               r_press;

    // The counter tracks consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts it.
    always_ff @(posedge tick or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_count  <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_count <= '0;
            end else if (r_count == c_cnt_last) begin
                r_count  <= '0;
                r_stable <= r_sync2;
                r_press  <= r_sync2;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/answer_capture.sv
// ============================================================================
// Module      : answer_capture
// Description : Captures the player's switch digit on a debounced press,
//               grades it against the expected value and keeps the score.
//               Optional answer timeout enabled by ANSWER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module answer_capture
    import calc_pkg::*;
#(
    parameter int         DEBOUNCE_TICKS = 4,
    parameter int         TIMEOUT_TICKS  = 1000,
    parameter logic [3:0] ANSWER_STATE   = c_state_answer,
    parameter logic [3:0] CLEAR_STATE    = c_state_start,
    parameter logic [3:0] BLANK_CODE     = c_blank_code
) (
    input  logic       tick,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic [3:0] switches,
    input  logic       enter_btn,
    input  logic [3:0] value,
    output logic [3:0] response,
    output logic       answer_done,
    output logic       correct,
    output logic [1:0] score,
    output logic       timed_out
);

    answer_state_t r_state;
    logic [3:0]    r_switches;
    logic [3:0]    r_response;
    logic          r_answer_done;
    logic          r_correct;
    logic [1:0]    r_score;
    logic          w_press;
    logic          w_digit_valid;
    logic          w_in_answer;

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn_debounce (
        .tick    (tick),
        .rst_n   (rst_n),
        .i_btn   (enter_btn),
        .o_press (w_press)
    );

    assign w_digit_valid = (r_switches <= 4'd9);
    assign w_in_answer   = (state == ANSWER_STATE);

`ifdef ANSWER_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_TICKS - 1);
    logic [15:0] r_timer;
    logic        r_timed_out;
`else
    localparam int c_unused_timeout = TIMEOUT_TICKS;
`endif

    always_ff @(posedge tick or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_switches    <= 4'd0;
            r_response    <= BLANK_CODE;
            r_answer_done <= 1'b0;
            r_correct     <= 1'b0;
            r_score       <= 2'd0;
`ifdef ANSWER_TIMEOUT_EN
            r_timer       <= 16'd0;
            r_timed_out   <= 1'b0;
`endif
        end else begin
            r_switches    <= switches;
            r_answer_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_response <= BLANK_CODE;
                    if (state == CLEAR_STATE) begin
                        r_score   <= 2'd0;
                        r_correct <= 1'b0;
`ifdef ANSWER_TIMEOUT_EN
                        r_timed_out <= 1'b0;
`endif
                    end
                    if (w_in_answer) begin
                        r_state <= ARMED;
`ifdef ANSWER_TIMEOUT_EN
                        r_timer <= 16'd0;
`endif
                    end
                end
                ARMED: begin
`ifdef ANSWER_TIMEOUT_EN
                    r_timer <= r_timer + 16'd1;
`endif
                    // Leaving the answer window outranks a coincident press.
                    if (!w_in_answer) begin
                        r_state    <= IDLE;
                        r_response <= BLANK_CODE;
                    end else if (w_press && w_digit_valid) begin
                        r_state       <= DONE;
                        r_response    <= r_switches;
                        r_answer_done <= 1'b1;
                        r_correct     <= (r_switches == value);
                        if ((r_switches == value) && (r_score != 2'd3)) begin
                            r_score <= r_score + 2'd1;
                        end
`ifdef ANSWER_TIMEOUT_EN
                        r_timed_out <= 1'b0;
                    end else if (r_timer == c_timeout_last) begin
                        r_state       <= DONE;
                        r_response    <= BLANK_CODE;
                        r_answer_done <= 1'b1;
                        r_correct     <= 1'b0;
                        r_timed_out   <= 1'b1;
`endif
                    end else begin
                        r_response <= w_digit_valid ? r_switches : BLANK_CODE;
                    end
                end
                DONE: begin
                    if (!w_in_answer) begin
                        r_state    <= IDLE;
                        r_response <= BLANK_CODE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_response <= BLANK_CODE;
                end
            endcase
        end
    end

    assign response    = r_response;
    assign answer_done = r_answer_done;
    assign correct     = r_correct;
    assign score       = r_score;
`ifdef ANSWER_TIMEOUT_EN
    assign timed_out   = r_timed_out;
`else
    assign timed_out   = 1'b0;
`endif

endmodule

`default_nettype wire
